// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between memory and the x86 decoder.
// Issues aligned 32-bit reads, buffers returned bytes in a circular byte queue,
// presents the oldest 4 bytes as a window and flushes on branch redirects.
// Ports:
//   i_clk, i_reset            clock (rising edge), async active-low reset
//   o_mem_address/cmd/valid   word-aligned read request, i_mem_ready accepts
//   i_mem_res_valid/data      read response, little-endian bytes
//   o_dec_data/valid          4-byte window ([7:0] oldest), valid at >= 4 bytes
//   i_dec_consume/size        pop i_dec_size+1 bytes when window valid
//   i_redirect/_addr          flush and restart fetch at any byte address
// Optional macro FETCH_STATS_EN adds o_stat_words / o_stat_stalls counters.
module fetch_queue #(
   parameter int                       ADDRESS_WIDTH = 32,
   parameter int                       DATA_WIDTH    = 32,
   parameter int                       QUEUE_BYTES   = 16,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   output logic [ADDRESS_WIDTH-1:0] o_mem_address,
   output logic                     o_mem_cmd,
   output logic                     o_mem_valid,
   input  logic                     i_mem_ready,
   input  logic                     i_mem_res_valid,
   input  logic [DATA_WIDTH-1:0]    i_mem_data,
   output logic [31:0]              o_dec_data,
   output logic                     o_dec_valid,
   input  logic                     i_dec_consume,
   input  logic [1:0]               i_dec_size,
   input  logic                     i_redirect,
   input  logic [ADDRESS_WIDTH-1:0] i_redirect_addr
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]              o_stat_words,
   output logic [31:0]              o_stat_stalls
`endif
);

   localparam int PW = $clog2(QUEUE_BYTES);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH = CW'(QUEUE_BYTES);
   localparam logic [CW-1:0] WORD  = CW'(4);
   localparam logic MEM_CMD_READ = 1'b0;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DROP = 2'd3;

   logic [1:0]               state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [PW-1:0]            rd_q, rd_d;
   logic [PW-1:0]            wr_q, wr_d;
   logic [CW-1:0]            count_q, count_d;
   logic [7:0]               queue_q [QUEUE_BYTES];
   logic [7:0]               queue_d [QUEUE_BYTES];

   logic [1:0]    skip;
   logic          dec_valid;
   logic          has_space;
   logic          mem_fire;
   logic          push;
   logic [2:0]    push_cnt;
   logic [2:0]    pop_cnt;
   logic [PW-1:0] wr_idx;
   logic [31:0]   window;

   // fetch_pc low bits are exactly the leading bytes of the next returned
   // word that lie before the fetch point; they drop to 0 once a word lands.
   assign skip      = fetch_pc_q[1:0];
   assign dec_valid = count_q >= WORD;
   assign has_space = (DEPTH - count_q) >= WORD;
   assign mem_fire  = o_mem_valid & i_mem_ready;
   assign push      = (state_q == S_WAIT) & i_mem_res_valid & ~i_redirect;
   assign push_cnt  = push ? 3'd4 - {1'b0, skip} : 3'd0;
   assign pop_cnt   = (i_dec_consume & dec_valid) ?
                      {1'b0, i_dec_size} + 3'd1 : 3'd0;

   always_comb begin
      queue_d = queue_q;
      wr_idx  = '0;
      if (push) begin
         for (int k = 0; k < 4; k++) begin
            if (2'(k) >= skip) begin
               wr_idx = wr_q + PW'(k) - PW'(skip);
               queue_d[wr_idx] = i_mem_data[8*k +: 8];
            end
         end
      end
   end

   always_comb begin
      rd_d    = rd_q + PW'(pop_cnt);
      wr_d    = wr_q + PW'(push_cnt);
      count_d = count_q + CW'(push_cnt) - CW'(pop_cnt);
      if (i_redirect) begin
         rd_d    = '0;
         wr_d    = '0;
         count_d = '0;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      unique case (state_q)
         S_IDLE: begin
            if (!i_redirect && has_space)
               state_d = S_REQ;
         end
         S_REQ: begin
            // An accepted request still returns data; it must be discarded.
            if (mem_fire)
               state_d = i_redirect ? S_DROP : S_WAIT;
            else if (i_redirect)
               state_d = S_IDLE;
         end
         S_WAIT: begin
            if (i_mem_res_valid) begin
               state_d = S_IDLE;
               fetch_pc_d = {fetch_pc_q[ADDRESS_WIDTH-1:2], 2'b00}
                            + ADDRESS_WIDTH'(4);
            end else if (i_redirect) begin
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (i_mem_res_valid)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (i_redirect)
         fetch_pc_d = i_redirect_addr;
   end

   always_comb begin
      window = '0;
      for (int k = 0; k < 4; k++)
         window[8*k +: 8] = queue_q[rd_q + PW'(k)];
   end

   assign o_mem_valid   = state_q == S_REQ;
   assign o_mem_address = {fetch_pc_q[ADDRESS_WIDTH-1:2], 2'b00};
   assign o_mem_cmd     = MEM_CMD_READ;
   assign o_dec_valid   = dec_valid;
   assign o_dec_data    = dec_valid ? window : 32'h0;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         rd_q       <= '0;
         wr_q       <= '0;
         count_q    <= '0;
         for (int k = 0; k < QUEUE_BYTES; k++)
            queue_q[k] <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         count_q    <= count_d;
         queue_q    <= queue_d;
      end
   end

`ifdef FETCH_STATS_EN
   logic [31:0] stat_words_q, stat_words_d;
   logic [31:0] stat_stalls_q, stat_stalls_d;

   always_comb begin
      stat_words_d  = stat_words_q;
      stat_stalls_d = stat_stalls_q;
      if (push && stat_words_q != 32'hFFFF_FFFF)
         stat_words_d = stat_words_q + 32'd1;
      if (!dec_valid && stat_stalls_q != 32'hFFFF_FFFF)
         stat_stalls_d = stat_stalls_q + 32'd1;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         stat_words_q  <= '0;
         stat_stalls_q <= '0;
      end else begin
         stat_words_q  <= stat_words_d;
         stat_stalls_q <= stat_stalls_d;
      end
   end

   assign o_stat_words  = stat_words_q;
   assign o_stat_stalls = stat_stalls_q;
`endif

endmodule
